// File: rtl/dma_cfg_regs_if.sv
// Register bus between a software-facing master and dma_cfg_regs.
// Every request is granted; one response per request, one cycle later.
interface dma_cfg_regs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dma_cfg_regs.sv
// Config/status register front-end for the DMA engine:
// programs length/addresses, sequences start/done, sticky status + irq.
module dma_cfg_regs #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  dma_cfg_regs_if.slave         bus,
  output logic [DATA_WIDTH-1:0] start_o,
  output logic [DATA_WIDTH-1:0] length_o,
  output logic [DATA_WIDTH-1:0] source_addr_lsb_o,
  output logic [DATA_WIDTH-1:0] source_addr_msb_o,
  output logic [DATA_WIDTH-1:0] dest_addr_lsb_o,
  output logic [DATA_WIDTH-1:0] dest_addr_msb_o,
  input  logic [DATA_WIDTH-1:0] dma_valid_i,
  output logic [DATA_WIDTH-1:0] done_o,
  output logic                  irq_o
);

  localparam int IW = ADDR_WIDTH - 2;

  localparam logic [IW-1:0] A_CTRL    = IW'(0);
  localparam logic [IW-1:0] A_LEN     = IW'(1);
  localparam logic [IW-1:0] A_SRC_LSB = IW'(2);
  localparam logic [IW-1:0] A_SRC_MSB = IW'(3);
  localparam logic [IW-1:0] A_DST_LSB = IW'(4);
  localparam logic [IW-1:0] A_DST_MSB = IW'(5);
  localparam logic [IW-1:0] A_STATUS  = IW'(6);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    ACK,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] length_q;
  logic [DATA_WIDTH-1:0] src_lsb_q;
  logic [DATA_WIDTH-1:0] src_msb_q;
  logic [DATA_WIDTH-1:0] dst_lsb_q;
  logic [DATA_WIDTH-1:0] dst_msb_q;
  logic                  irq_en;
  logic                  st_load;
  logic                  st_store;
  logic                  st_done;
  logic                  st_timeout;
  logic [31:0]           cnt;

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [IW-1:0]         widx;
  logic                  idle;
  logic                  wr;
  logic                  mapped;
  logic                  cfg_sel;
  logic                  ctrl_sel;
  logic                  err_c;
  logic                  wr_ok;
  logic                  go;
  logic                  clr;
  logic                  dma_done;
  logic                  busy_done;
  logic                  tmo_hit;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_bits;

  assign widx     = bus.addr[ADDR_WIDTH-1:2];
  assign idle     = (state == IDLE);
  assign wr       = bus.req & bus.we;
  assign dma_done = dma_valid_i[3];
  assign tmo_hit  = TO_EN && (cnt == TO_LAST);

  assign unused_bits = ^{bus.addr[1:0],
                         dma_valid_i[DATA_WIDTH-1:4],
                         dma_valid_i[0]};

  always_comb begin
    mapped   = 1'b1;
    cfg_sel  = 1'b0;
    ctrl_sel = 1'b0;
    rd_val   = '0;
    case (widx)
      A_CTRL: begin
        ctrl_sel  = 1'b1;
        rd_val[1] = irq_en;
      end
      A_LEN: begin
        cfg_sel = 1'b1;
        rd_val  = length_q;
      end
      A_SRC_LSB: begin
        cfg_sel = 1'b1;
        rd_val  = src_lsb_q;
      end
      A_SRC_MSB: begin
        cfg_sel = 1'b1;
        rd_val  = src_msb_q;
      end
      A_DST_LSB: begin
        cfg_sel = 1'b1;
        rd_val  = dst_lsb_q;
      end
      A_DST_MSB: begin
        cfg_sel = 1'b1;
        rd_val  = dst_msb_q;
      end
      A_STATUS: begin
        rd_val[4:0] = {st_timeout, st_done, st_store,
                       st_load, ~idle};
      end
      default: mapped = 1'b0;
    endcase
  end

  // Any rejected request leaves all state untouched,
  // including irq_en/CLR bits of a refused GO write.
  assign err_c = bus.req & (~mapped
               | (wr & (widx == A_STATUS))
               | (wr & cfg_sel & ~idle)
               | (wr & ctrl_sel & bus.wdata[0] & ~idle)
               | (wr & (widx == A_LEN) & (&bus.wdata)));

  assign wr_ok = wr & ~err_c;
  assign go    = wr_ok & ctrl_sel & bus.wdata[0];
  assign clr   = wr_ok & ctrl_sel & bus.wdata[2];

  assign busy_done = (state == BUSY) & dma_done;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = START;
      START:   state_n = BUSY;
      BUSY: begin
        if (dma_done)     state_n = ACK;
        else if (tmo_hit) state_n = IDLE;
      end
      ACK:     state_n = DRAIN;
      DRAIN:   if (!dma_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                cnt <= '0;
    else if (state != BUSY)     cnt <= '0;
    else if (cnt != '1)         cnt <= cnt + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      length_q  <= '0;
      src_lsb_q <= '0;
      src_msb_q <= '0;
      dst_lsb_q <= '0;
      dst_msb_q <= '0;
      irq_en    <= 1'b0;
    end else if (wr_ok) begin
      case (widx)
        A_CTRL:    irq_en    <= bus.wdata[1];
        A_LEN:     length_q  <= bus.wdata;
        A_SRC_LSB: src_lsb_q <= bus.wdata;
        A_SRC_MSB: src_msb_q <= bus.wdata;
        A_DST_LSB: dst_lsb_q <= bus.wdata;
        A_DST_MSB: dst_msb_q <= bus.wdata;
        default:   ;
      endcase
    end
  end

  // Later assignments win: GO after CLR, DONE over timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_load    <= 1'b0;
      st_store   <= 1'b0;
      st_done    <= 1'b0;
      st_timeout <= 1'b0;
    end else begin
      if (clr) begin
        st_done    <= 1'b0;
        st_timeout <= 1'b0;
      end
      if (go) begin
        st_load    <= 1'b0;
        st_store   <= 1'b0;
        st_done    <= 1'b0;
        st_timeout <= 1'b0;
      end
      if (busy_done) begin
        st_load  <= dma_valid_i[1];
        st_store <= dma_valid_i[2];
        st_done  <= 1'b1;
      end else if ((state == BUSY) && tmo_hit) begin
        st_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= bus.req;
      rdata_q  <= (bus.req & ~bus.we) ? rd_val : '0;
      err_q    <= err_c;
    end
  end

  assign bus.gnt    = bus.req;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;

  assign start_o           = DATA_WIDTH'(state == START);
  assign done_o            = DATA_WIDTH'(state == ACK);
  assign length_o          = length_q;
  assign source_addr_lsb_o = src_lsb_q;
  assign source_addr_msb_o = src_msb_q;
  assign dest_addr_lsb_o   = dst_lsb_q;
  assign dest_addr_msb_o   = dst_msb_q;
  assign irq_o             = irq_en & (st_done | st_timeout);

endmodule
